// File: rtl/cache_pkg.sv
// Shared types and constants for the cache fill arbiter.
package cache_pkg;
  typedef enum logic [1:0] {IDLE, FILL_D, FILL_I} fill_state_t;
  localparam logic [15:0] BLOCK_MASK = 16'hFFF0;
  localparam int WORDS = 8;
  localparam int MEM_LAT = 4;
endpackage

// File: rtl/cache_fill_arbiter_word_counter.sv
// Block word index counter with synchronous clear and a last-word flag.
module word_counter #(
  parameter int WORDS = cache_pkg::WORDS,
  localparam int CW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          last
);
  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CW'(WORDS - 1));
endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D cache block fills and write-through stores onto one memory port.
module cache_fill_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = cache_pkg::WORDS,
  localparam int CW = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_write_addr,
  input  logic [DATA_W-1:0] d_write_data,
  output logic              i_stall,
  output logic              d_stall,
  output logic              fill_i_we,
  output logic              fill_d_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_done_i,
  output logic              fill_done_d,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_data_valid
);
  fill_state_t       state_d, state_q;
  logic [ADDR_W-1:0] base_d, base_q;
  logic              issued_d, issued_q;
  logic [CW-1:0]     issue_cnt, rcv_cnt;
  logic              issue_last, rcv_last;
  logic              filling, issue_go, rcv_go, cnt_clr;

  word_counter #(.WORDS(WORDS)) u_issue (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(issue_go), .cnt(issue_cnt), .last(issue_last)
  );
  word_counter #(.WORDS(WORDS)) u_rcv (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(rcv_go), .cnt(rcv_cnt), .last(rcv_last)
  );

  always_comb begin
    filling      = (state_q != IDLE);
    issue_go     = filling & ~issued_q;
    rcv_go       = filling & mem_data_valid;
    cnt_clr      = rcv_go & rcv_last;
    state_d      = state_q;
    base_d       = base_q;
    issued_d     = issued_q;
    fill_i_we    = 1'b0;
    fill_d_we    = 1'b0;
    fill_addr    = '0;
    fill_data    = '0;
    fill_done_i  = 1'b0;
    fill_done_d  = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_out = '0;
    case (state_q)
      IDLE: begin
        if (d_write & ~d_miss) begin
          mem_en       = 1'b1;
          mem_wr       = 1'b1;
          mem_addr     = d_write_addr;
          mem_data_out = d_write_data;
        end else if (d_miss) begin
          base_d  = d_miss_addr & ADDR_W'(BLOCK_MASK);
          state_d = FILL_D;
        end else if (i_miss) begin
          base_d  = i_miss_addr & ADDR_W'(BLOCK_MASK);
          state_d = FILL_I;
        end
      end
      default: begin
        if (issue_go) begin
          mem_en   = 1'b1;
          mem_addr = base_q + ADDR_W'({issue_cnt, 1'b0});
          if (issue_last) issued_d = 1'b1;
        end
        if (rcv_go) begin
          fill_i_we = (state_q == FILL_I);
          fill_d_we = (state_q == FILL_D);
          fill_addr = base_q + ADDR_W'({rcv_cnt, 1'b0});
          fill_data = mem_data_in;
          if (rcv_last) begin
            fill_done_i = (state_q == FILL_I);
            fill_done_d = (state_q == FILL_D);
            issued_d    = 1'b0;
            state_d     = IDLE;
          end
        end
      end
    endcase
    d_stall = d_miss | (state_q == FILL_D) | (d_write & filling);
    i_stall = i_miss | (state_q == FILL_I);
    // Reset wins over everything, including a fill caught mid-flight.
    if (rst) begin
      d_stall     = 1'b0;
      i_stall     = 1'b0;
      fill_i_we   = 1'b0;
      fill_d_we   = 1'b0;
      fill_addr   = '0;
      fill_data   = '0;
      fill_done_i = 1'b0;
      fill_done_d = 1'b0;
      mem_en      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_data_out = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      issued_q <= issued_d;
    end
  end
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed scoreboard bench for cache_fill_arbiter with a 4-cycle memory model.
module tb_cache_fill_arbiter;
  localparam int MEM_LAT = 4;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
    bit          is_i;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_miss = 1'b0, d_miss = 1'b0, d_write = 1'b0;
  logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_write_addr = '0, d_write_data = '0;
  logic i_stall, d_stall, fill_i_we, fill_d_we, fill_done_i, fill_done_d, mem_en, mem_wr;
  logic [15:0] fill_addr, fill_data, mem_addr, mem_data_out, mem_data_in;
  logic mem_data_valid;

  logic [MEM_LAT-1:0] vpipe = '0;
  logic [15:0] apipe [MEM_LAT];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  ev_t rd_q[$], wr_q[$], fill_q[$], done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main memory: reads return addr^A5A5 MEM_LAT cycles after issue.
  initial for (int i = 0; i < MEM_LAT; i++) apipe[i] = '0;
  always @(posedge clk) begin
    vpipe    <= {vpipe[MEM_LAT-2:0], mem_en & ~mem_wr};
    apipe[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign mem_data_valid = vpipe[MEM_LAT-1];
  assign mem_data_in    = apipe[MEM_LAT-1] ^ 16'hA5A5;

  cache_fill_arbiter dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_write(d_write), .d_write_addr(d_write_addr), .d_write_data(d_write_data),
    .i_stall(i_stall), .d_stall(d_stall),
    .fill_i_we(fill_i_we), .fill_d_we(fill_d_we),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .fill_done_i(fill_done_i), .fill_done_d(fill_done_d),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid)
  );

  wire [71:0] outs = {i_stall, d_stall, fill_i_we, fill_d_we, fill_addr, fill_data,
                      fill_done_i, fill_done_d, mem_en, mem_wr, mem_addr, mem_data_out};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Expected traffic of one block fill whose miss is sampled in IDLE at cycle t.
  task automatic push_fill(input int t, input logic [15:0] base, input bit is_i);
    ev_t e;
    for (int k = 0; k < 8; k++) begin
      e.addr = base + 16'(2 * k);
      e.data = e.addr ^ 16'hA5A5;
      e.is_i = is_i;
      e.cyc  = t + 1 + k;
      rd_q.push_back(e);
      e.cyc  = t + 5 + k;
      fill_q.push_back(e);
    end
    e.cyc = t + 12;
    done_q.push_back(e);
  endtask

  task automatic wait_done(input string tag, input bit want_i, input bit exp_i, input bit exp_d);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      chk({tag, "_istall"}, i_stall, exp_i);
      chk({tag, "_dstall"}, d_stall, exp_d);
      seen = want_i ? fill_done_i : fill_done_d;
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (mem_en && mem_wr) begin
      if (wr_q.size() == 0) chk("wr_unexpected", mem_addr, 16'hFFFF);
      else begin
        e = wr_q.pop_front();
        chk("wr_cyc", cyc, e.cyc);
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_data_out, e.data);
      end
    end else if (mem_en) begin
      if (rd_q.size() == 0) chk("rd_unexpected", mem_addr, 16'hFFFF);
      else begin
        e = rd_q.pop_front();
        chk("rd_cyc", cyc, e.cyc);
        chk("rd_addr", mem_addr, e.addr);
      end
    end
    if (fill_i_we || fill_d_we) begin
      if (fill_q.size() == 0) chk("fill_unexpected", fill_addr, 16'hFFFF);
      else begin
        e = fill_q.pop_front();
        chk("fill_cyc", cyc, e.cyc);
        chk("fill_addr", fill_addr, e.addr);
        chk("fill_data", fill_data, e.data);
        chk("fill_port", {fill_i_we, fill_d_we}, {e.is_i, ~e.is_i});
      end
    end
    if (fill_done_i || fill_done_d) begin
      if (done_q.size() == 0) chk("done_unexpected", {fill_done_i, fill_done_d}, 0);
      else begin
        e = done_q.pop_front();
        chk("done_cyc", cyc, e.cyc);
        chk("done_port", {fill_done_i, fill_done_d}, {e.is_i, ~e.is_i});
      end
    end
  end

  initial begin
    int t0;
    // Reset with every request asserted: outputs must stay quiet.
    i_miss = 1'b1; d_miss = 1'b1; d_write = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("reset_outs", |outs, 0);
    step();
    rst = 1'b0; i_miss = 1'b0; d_miss = 1'b0; d_write = 1'b0;
    @(negedge clk);
    chk("post_reset_outs", |outs, 0);

    // D miss, 13-cycle latency to stall release.
    step();
    d_miss = 1'b1; d_miss_addr = 16'h1236; t0 = cyc;
    push_fill(t0, 16'h1230, 1'b0);
    wait_done("dmiss", 1'b0, 1'b0, 1'b1);
    step();
    d_miss = 1'b0;
    @(negedge clk);
    chk("dmiss_release_cyc", cyc, t0 + 13);
    chk("dmiss_release", d_stall, 0);

    // Simultaneous I and D miss: D first, I starts at cycle 14.
    step();
    i_miss = 1'b1; i_miss_addr = 16'h0040; d_miss = 1'b1; d_miss_addr = 16'h2000; t0 = cyc;
    push_fill(t0, 16'h2000, 1'b0);
    push_fill(t0 + 13, 16'h0040, 1'b1);
    wait_done("both_d", 1'b0, 1'b1, 1'b1);
    step();
    d_miss = 1'b0;
    wait_done("both_i", 1'b1, 1'b1, 1'b0);
    step();
    i_miss = 1'b0;
    @(negedge clk);
    chk("both_release_cyc", cyc, t0 + 26);
    chk("both_release", i_stall, 0);

    // Store hit in IDLE.
    step();
    d_write = 1'b1; d_write_addr = 16'h3002; d_write_data = 16'hBEEF;
    wr_q.push_back('{cyc, 16'h3002, 16'hBEEF, 1'b0});
    @(negedge clk);
    chk("store_dstall", d_stall, 0);
    chk("store_istall", i_stall, 0);
    step();
    d_write = 1'b0;
    @(negedge clk);
    chk("store_idle_quiet", |outs, 0);

    // Store during FILL_I waits for IDLE and beats a new I miss.
    step();
    i_miss = 1'b1; i_miss_addr = 16'h0100; t0 = cyc;
    push_fill(t0, 16'h0100, 1'b1);
    repeat (3) step();
    d_write = 1'b1; d_write_addr = 16'h0200; d_write_data = 16'h1234;
    wait_done("wfi", 1'b1, 1'b1, 1'b1);
    step();
    i_miss_addr = 16'h0300;
    wr_q.push_back('{t0 + 13, 16'h0200, 16'h1234, 1'b0});
    push_fill(t0 + 14, 16'h0300, 1'b1);
    @(negedge clk);
    chk("wfi_write_cyc_dstall", d_stall, 0);
    step();
    d_write = 1'b0;
    wait_done("wfi_i2", 1'b1, 1'b1, 1'b0);
    step();
    i_miss = 1'b0;

    // Reset pulsed in cycle 7 of a fill.
    step();
    d_miss = 1'b1; d_miss_addr = 16'h4000; t0 = cyc;
    for (int k = 0; k < 6; k++) rd_q.push_back('{t0 + 1 + k, 16'h4000 + 16'(2 * k), 16'h0, 1'b0});
    for (int k = 0; k < 2; k++)
      fill_q.push_back('{t0 + 5 + k, 16'h4000 + 16'(2 * k), (16'h4000 + 16'(2 * k)) ^ 16'hA5A5, 1'b0});
    repeat (7) step();
    rst = 1'b1; d_miss = 1'b0;
    @(negedge clk);
    chk("midrst_outs", |outs, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_next_outs", |outs, 0);
    repeat (6) begin
      step();
      @(negedge clk);
      chk("midrst_stray", {fill_i_we, fill_d_we, fill_done_i, fill_done_d}, 0);
    end

    // Top-of-memory block: no wrap past 0xFFFE.
    step();
    d_miss = 1'b1; d_miss_addr = 16'hFFF8; t0 = cyc;
    push_fill(t0, 16'hFFF0, 1'b0);
    wait_done("top", 1'b0, 1'b0, 1'b1);
    step();
    d_miss = 1'b0;
    repeat (6) step();

    chk("rd_left", rd_q.size(), 0);
    chk("wr_left", wr_q.size(), 0);
    chk("fill_left", fill_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
